// File: rtl/sr_bank_arbiter_pkg.sv
// Shared op encoding and helpers for the SR bank arbiter and requester-side logic.
package sr_bank_arbiter_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // NOP ops never enter arbitration, even with req asserted.
  function automatic logic op_active(input op_e o);
    return o != OP_NOP;
  endfunction

endpackage

// File: rtl/sr_cell_bank.sv
// Bank of W clocked SR storage cells with complementary outputs.
module sr_cell_bank #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s,
  input  logic [W-1:0] r,
  output logic [W-1:0] q,
  output logic [W-1:0] qbar
);

  logic [W-1:0] q_nxt;

  // Per-bit SR behaviour; s=r=1 is never driven and yields x if it ever is.
  always_comb begin
    q_nxt = q;
    for (int unsigned i = 0; i < W; i++) begin
      case ({s[i], r[i]})
        2'b10:   q_nxt[i] = 1'b1;
        2'b01:   q_nxt[i] = 1'b0;
        2'b11:   q_nxt[i] = 1'bx;
        default: q_nxt[i] = q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      qbar <= '1;
    end else begin
      q    <= q_nxt;
      qbar <= ~q_nxt;
    end
  end

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter serialising SET/CLR/LOAD ops from N requesters onto one SR cell bank.
module sr_bank_arbiter
  import sr_bank_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [OP_W*N-1:0] op,
  input  logic [W*N-1:0]  mask,
  input  logic [W*N-1:0]  data,
  output logic [N-1:0]    gnt,
  output logic [W-1:0]    q,
  output logic [W-1:0]    qbar,
  output logic            busy
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     elig;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  op_e              sel_op;
  logic [W-1:0]     sel_mask;
  logic [W-1:0]     sel_data;
  logic [W-1:0]     s_nxt;
  logic [W-1:0]     r_nxt;
  logic [W-1:0]     s_stg;
  logic [W-1:0]     r_stg;

  // A requester granted last cycle sits out one cycle so a held req is not reapplied.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      elig[i] = req[i] && op_active(op_e'(op[OP_W*i +: OP_W])) && !gnt[i];
    end
  end

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(rr_ptr) + k) % N;
      if (!win_found && elig[PTR_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    sel_op   = OP_NOP;
    sel_mask = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_found && (win_idx == PTR_W'(i))) begin
        sel_op   = op_e'(op[OP_W*i +: OP_W]);
        sel_mask = mask[W*i +: W];
        sel_data = data[W*i +: W];
      end
    end
  end

  // Op decode; s and r are disjoint by construction for every opcode.
  always_comb begin
    s_nxt = '0;
    r_nxt = '0;
    case (sel_op)
      OP_SET: s_nxt = sel_mask;
      OP_CLR: r_nxt = sel_mask;
      OP_LOAD: begin
        s_nxt = sel_mask & sel_data;
        r_nxt = sel_mask & ~sel_data;
      end
      default: begin
        s_nxt = '0;
        r_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= '0;
      busy   <= 1'b0;
      s_stg  <= '0;
      r_stg  <= '0;
      rr_ptr <= '0;
    end else if (win_found) begin
      gnt    <= N'(1) << win_idx;
      busy   <= 1'b1;
      s_stg  <= s_nxt;
      r_stg  <= r_nxt;
      rr_ptr <= (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + PTR_W'(1);
    end else begin
      gnt    <= '0;
      busy   <= 1'b0;
      s_stg  <= '0;
      r_stg  <= '0;
    end
  end

  sr_cell_bank #(
    .W (W)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .s    (s_stg),
    .r    (r_stg),
    .q    (q),
    .qbar (qbar)
  );

  a_no_forbidden: assert property (@(posedge clk) (s_stg & r_stg) == '0)
    else $error("sr_bank_arbiter: s and r both high on a cell");

  a_nxt_disjoint: assert property (@(posedge clk) (s_nxt & r_nxt) == '0)
    else $error("sr_bank_arbiter: decoded s/r overlap");

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed self-checking bench for sr_bank_arbiter (N=4, W=8).
module tb_sr_bank_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [2*N-1:0] op;
  logic [W*N-1:0] mask;
  logic [W*N-1:0] data;
  logic [N-1:0] gnt;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         busy;

  int checks;
  int errors;

  sr_bank_arbiter #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .op   (op),
    .mask (mask),
    .data (data),
    .gnt  (gnt),
    .q    (q),
    .qbar (qbar),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int i, input logic r, input logic [1:0] o,
                       input logic [7:0] m, input logic [7:0] d);
    req[i]        = r;
    op[2*i +: 2]  = o;
    mask[8*i +: 8] = m;
    data[8*i +: 8] = d;
  endtask

  task automatic idle_all();
    req  = '0;
    op   = '0;
    mask = '0;
    data = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", q); end
    checks++; if (qbar !== 8'hFF) begin errors++; $display("FAIL reset_qbar got %h exp ff", qbar); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    drive(0, 1'b1, 2'b01, 8'hFF, 8'h00);
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL midop_gnt got %b exp 0001", gnt); end
    drive(0, 1'b0, 2'b00, 8'h00, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL midop_q got %h exp 00", q); end
    checks++; if (qbar !== 8'hFF) begin errors++; $display("FAIL midop_qbar got %h exp ff", qbar); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL midop_gnt_rst got %b exp 0000", gnt); end
    @(negedge clk);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL midop_q_after got %h exp 00", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midop_busy got %b exp 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 1'b1, 2'b01, 8'h0F, 8'h00);
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL single_q_early got %h exp 00", q); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_held got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_held got %b exp 0", busy); end
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL single_q got %h exp 0f", q); end
    checks++; if (qbar !== 8'hF0) begin errors++; $display("FAIL single_qbar got %h exp f0", qbar); end
    drive(0, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_end got %b exp 0000", gnt); end
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL single_q_end got %h exp 0f", q); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    int cnt [4];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cnt = '{0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 2'b01, 8'(1 << i), 8'h00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== exp_g[c]) begin
        errors++; $display("FAIL rr_gnt cycle %0d got %b exp %b", c, gnt, exp_g[c]);
      end
      if (c < 4) for (int i = 0; i < 4; i++) if (gnt[i]) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] != 1) begin errors++; $display("FAIL rr_count req%0d got %0d exp 1", i, cnt[i]); end
    end
    idle_all();
    @(negedge clk);
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL rr_q got %h exp 0f", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got %b exp 0", busy); end
  endtask

  task automatic test_load();
    do_reset();
    drive(0, 1'b1, 2'b01, 8'hAA, 8'h00);
    @(negedge clk);
    drive(0, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (q !== 8'hAA) begin errors++; $display("FAIL load_pre_q got %h exp aa", q); end
    drive(2, 1'b1, 2'b11, 8'hF0, 8'h5C);
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL load_gnt got %b exp 0100", gnt); end
    drive(2, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL load_q got %h exp 5a", q); end
    checks++; if (qbar !== 8'hA5) begin errors++; $display("FAIL load_qbar got %h exp a5", qbar); end
  endtask

  task automatic test_contention();
    do_reset();
    drive(1, 1'b1, 2'b01, 8'h01, 8'h00);
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL cont_setup_gnt got %b exp 0010", gnt); end
    drive(1, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL cont_setup_q got %h exp 01", q); end
    drive(1, 1'b1, 2'b01, 8'h01, 8'h00);
    drive(3, 1'b1, 2'b10, 8'h01, 8'h00);
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL cont_first_gnt got %b exp 1000", gnt); end
    drive(3, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL cont_second_gnt got %b exp 0010", gnt); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL cont_clr_q got %h exp 00", q); end
    drive(1, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL cont_set_q got %h exp 01", q); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL cont_end_gnt got %b exp 0000", gnt); end
  endtask

  task automatic test_nop();
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 2'b00, 8'hFF, 8'hFF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL nop_gnt cycle %0d got %b exp 0000", c, gnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nop_busy cycle %0d got %b exp 0", c, busy); end
      checks++; if (q !== 8'h01) begin errors++; $display("FAIL nop_q cycle %0d got %h exp 01", c, q); end
    end
    idle_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_all();
    test_reset();
    test_reset_mid_op();
    test_single();
    test_round_robin();
    test_load();
    test_contention();
    test_nop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
